camera_ctrl_fsm: RTL and testbench

- Sequencing controller for the pixel-array datapath built from the team's gate library.
- Owns the capture cycle: IDLE (pixel erase) -> EXPOSURE -> READOUT (row-by-row read enables plus ADC strobe).
- Holds a programmable exposure-time register, adjusted by increment/decrement requests.
- Sits between the top-level user controls and the pixel/ADC datapath.

---
 rtl/camera_ctrl_if.sv | 26 ++
 rtl/camera_ctrl_fsm.sv | 152 +++++++++++++++
 tb/tb_camera_ctrl_fsm.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/camera_ctrl_if.sv
// Bus between the user controls and the capture sequencer.
interface camera_ctrl_if #(
    parameter int NUM_ROWS = 2,
    parameter int EXP_W    = 5
);
    logic                init;
    logic                exp_inc;
    logic                exp_dec;
    logic                erase;
    logic                expose;
    logic [NUM_ROWS-1:0] nre;
    logic                adc;
    logic                busy;
    logic                done;
    logic [EXP_W-1:0]    exp_time;

    modport master (
        output init, exp_inc, exp_dec,
        input  erase, expose, nre, adc, busy, done, exp_time
    );

    modport slave (
        input  init, exp_inc, exp_dec,
        output erase, expose, nre, adc, busy, done, exp_time
    );
endinterface

// File: rtl/camera_ctrl_fsm.sv
// Capture sequencer: pixel erase, timed exposure, then row-by-row readout
// with an ADC strobe in the middle of each row's read window.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | pixels held in erase; exposure adjust and capture request
// S_EXPOSE | integration for exp_time cycles, settings frozen
// S_READ   | 4 cycles per row: enable, enable+adc, enable, gap
module camera_ctrl_fsm #(
    parameter int EXP_MIN   = 2,
    parameter int EXP_MAX   = 30,
    parameter int EXP_RESET = 16,
    parameter int NUM_ROWS  = 2,
    parameter int EXP_W     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    camera_ctrl_if.slave  bus
);

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [EXP_W-1:0]    EXP_MIN_V   = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0]    EXP_MAX_V   = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0]    EXP_RESET_V = EXP_W'(EXP_RESET);
    localparam logic [ROW_W-1:0]    ROW_LAST    = ROW_W'(NUM_ROWS - 1);
    localparam logic [NUM_ROWS-1:0] ROW_ONE     = NUM_ROWS'(1);
    localparam logic [NUM_ROWS-1:0] NRE_OFF     = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPOSE = 2'd1,
        S_READ   = 2'd2
    } state_t;

    state_t              state;
    logic [EXP_W-1:0]    exp_time;
    logic [EXP_W-1:0]    exp_cnt;
    logic [ROW_W-1:0]    row;
    logic [1:0]          phase;
    logic                erase;
    logic                expose;
    logic [NUM_ROWS-1:0] nre;
    logic                adc;
    logic                busy;
    logic                done;

    // Active-low enable pattern selecting a single row.
    function automatic logic [NUM_ROWS-1:0] row_sel(input logic [ROW_W-1:0] r);
        return ~(ROW_ONE << r);
    endfunction

    // Sequencer state, counters and registered outputs; outputs always
    // describe the state being entered at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            exp_time <= EXP_RESET_V;
            exp_cnt  <= '0;
            row      <= '0;
            phase    <= '0;
            erase    <= 1'b1;
            expose   <= 1'b0;
            nre      <= NRE_OFF;
            adc      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    adc  <= 1'b0;
                    nre  <= NRE_OFF;
                    if (bus.init) begin
                        state   <= S_EXPOSE;
                        exp_cnt <= exp_time;
                        erase   <= 1'b0;
                        expose  <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        erase  <= 1'b1;
                        expose <= 1'b0;
                        busy   <= 1'b0;
                        if (bus.exp_inc && !bus.exp_dec) begin
                            if (exp_time < EXP_MAX_V)
                                exp_time <= exp_time + EXP_W'(1);
                        end else if (bus.exp_dec && !bus.exp_inc) begin
                            if (exp_time > EXP_MIN_V)
                                exp_time <= exp_time - EXP_W'(1);
                        end
                    end
                end

                S_EXPOSE: begin
                    // Counter was loaded with exp_time on entry, so the
                    // terminal count of 1 ends the exposure after exp_time cycles.
                    if ((exp_cnt == EXP_W'(1)) || (exp_cnt == '0)) begin
                        state  <= S_READ;
                        row    <= '0;
                        phase  <= '0;
                        expose <= 1'b0;
                        nre    <= row_sel('0);
                    end else begin
                        exp_cnt <= exp_cnt - EXP_W'(1);
                    end
                end

                S_READ: begin
                    if (phase == 2'd3) begin
                        done <= 1'b0;
                        if (row == ROW_LAST) begin
                            state <= S_IDLE;
                            erase <= 1'b1;
                            busy  <= 1'b0;
                            nre   <= NRE_OFF;
                        end else begin
                            row   <= row + ROW_W'(1);
                            phase <= 2'd0;
                            nre   <= row_sel(row + ROW_W'(1));
                        end
                    end else begin
                        phase <= phase + 2'd1;
                        adc   <= (phase == 2'd0);
                        if (phase == 2'd2) begin
                            nre  <= NRE_OFF;
                            done <= (row == ROW_LAST);
                        end
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    erase  <= 1'b1;
                    expose <= 1'b0;
                    nre    <= NRE_OFF;
                    adc    <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.erase    = erase;
    assign bus.expose   = expose;
    assign bus.nre      = nre;
    assign bus.adc      = adc;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.exp_time = exp_time;

endmodule

// File: tb/tb_camera_ctrl_fsm.sv
// Bench for camera_ctrl_fsm: a capture-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_camera_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    camera_ctrl_if #(.NUM_ROWS(2), .EXP_W(5)) bus();

    camera_ctrl_fsm #(
        .EXP_MIN(2), .EXP_MAX(30), .EXP_RESET(16), .NUM_ROWS(2), .EXP_W(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a capture is a timeline of length exp+8 cycles indexed by pos.
    bit started = 0;
    bit m_cap   = 0;
    int m_pos   = 0;
    int m_len   = 0;
    int m_exp   = 16;

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1;
            m_cap   = 0;
            m_exp   = 16;
        end else if (started) begin
            if (!m_cap) begin
                if (bus.init) begin
                    m_cap = 1;
                    m_pos = 0;
                    m_len = m_exp;
                end else if (bus.exp_inc && !bus.exp_dec) begin
                    m_exp = (m_exp + 1 > 30) ? 30 : m_exp + 1;
                end else if (bus.exp_dec && !bus.exp_inc) begin
                    m_exp = (m_exp - 1 < 2) ? 2 : m_exp - 1;
                end
            end else if (m_pos == m_len + 7) begin
                m_cap = 0;
            end else begin
                m_pos++;
            end
        end
    end

    // Compare DUT against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        int k;
        logic e_erase, e_expose, e_adc, e_busy, e_done;
        logic [1:0] e_nre;
        if (started) begin
            e_erase = 1; e_expose = 0; e_adc = 0; e_busy = 0; e_done = 0; e_nre = 2'b11;
            if (m_cap) begin
                e_erase = 0;
                e_busy  = 1;
                if (m_pos < m_len) begin
                    e_expose = 1;
                end else begin
                    k = m_pos - m_len;
                    e_nre  = (k % 4 == 3) ? 2'b11 : 2'(~(32'd1 << (k / 4)));
                    e_adc  = (k % 4 == 1);
                    e_done = (k == 7);
                end
            end
            chk("cmp_erase",    bus.erase,    e_erase);
            chk("cmp_expose",   bus.expose,   e_expose);
            chk("cmp_nre",      bus.nre,      e_nre);
            chk("cmp_adc",      bus.adc,      e_adc);
            chk("cmp_busy",     bus.busy,     e_busy);
            chk("cmp_done",     bus.done,     e_done);
            chk("cmp_exp_time", bus.exp_time, m_exp);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One capture from IDLE: measure exposure length and readout pattern.
    task automatic capture(input int exp_len, input logic with_inc);
        int n;
        int guard;
        logic [15:0] nre_seq;
        logic [7:0]  adc_seq;
        logic [7:0]  done_seq;
        bus.init    = 1;
        bus.exp_inc = with_inc;
        @(posedge clk); #1;
        bus.init = 0;
        @(negedge clk);
        n = 0;
        guard = 0;
        while (bus.expose && guard < 200) begin
            n++;
            guard++;
            @(negedge clk);
        end
        bus.exp_inc = 0;
        chk("exp_len", n, exp_len);
        nre_seq = '0; adc_seq = '0; done_seq = '0;
        for (int i = 0; i < 8; i++) begin
            nre_seq  = {nre_seq[13:0], bus.nre};
            adc_seq  = {adc_seq[6:0], bus.adc};
            done_seq = {done_seq[6:0], bus.done};
            @(negedge clk);
        end
        chk("nre_seq",     nre_seq,  16'hAB57);
        chk("adc_seq",     adc_seq,  8'h44);
        chk("done_seq",    done_seq, 8'h01);
        chk("erase_after", bus.erase, 1);
    endtask

    initial begin
        int guard;
        int cnt;
        int d[3];
        int nd;

        rst_n = 0;
        bus.init = 0; bus.exp_inc = 0; bus.exp_dec = 0;
        step(2);
        rst_n = 1;
        step(2);
        @(negedge clk);
        chk("rst_exp_time", bus.exp_time, 16);
        chk("rst_erase",    bus.erase, 1);
        chk("rst_expose",   bus.expose, 0);
        chk("rst_nre",      bus.nre, 2'b11);
        chk("rst_adc",      bus.adc, 0);
        chk("rst_busy",     bus.busy, 0);
        chk("rst_done",     bus.done, 0);

        step(1);
        capture(16, 0);

        step(1);
        bus.exp_inc = 1;
        step(20);
        bus.exp_inc = 0;
        @(negedge clk);
        chk("inc_sat", bus.exp_time, 30);
        step(1);
        capture(30, 0);

        step(1);
        bus.exp_dec = 1;
        step(40);
        bus.exp_dec = 0;
        @(negedge clk);
        chk("dec_sat", bus.exp_time, 2);
        step(1);
        capture(2, 0);

        step(1);
        bus.exp_inc = 1; bus.exp_dec = 1;
        step(5);
        bus.exp_inc = 0; bus.exp_dec = 0;
        @(negedge clk);
        chk("both_hold", bus.exp_time, 2);

        // init together with exp_inc, and exp_inc held through exposure.
        step(1);
        capture(2, 1);
        chk("init_inc_exp", bus.exp_time, 2);

        // Back-to-back captures with init held high.
        step(1);
        bus.init = 1;
        nd = 0;
        d[0] = 0; d[1] = 0; d[2] = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done && nd < 3) begin
                d[nd] = c;
                nd++;
            end
        end
        bus.init = 0;
        chk("b2b_count", nd, 3);
        chk("b2b_gap0", d[1] - d[0], 11);
        chk("b2b_gap1", d[2] - d[1], 11);
        step(15);

        // Reset during readout row 1, phase 1.
        bus.init = 1;
        step(1);
        bus.init = 0;
        guard = 0;
        @(negedge clk);
        while (!(bus.nre == 2'b01 && bus.adc) && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) chk("find_row1_p1", 0, 1);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("abort_erase",    bus.erase, 1);
        chk("abort_expose",   bus.expose, 0);
        chk("abort_nre",      bus.nre, 2'b11);
        chk("abort_adc",      bus.adc, 0);
        chk("abort_busy",     bus.busy, 0);
        chk("abort_done",     bus.done, 0);
        chk("abort_exp_time", bus.exp_time, 16);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
